// File: rtl/branch_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : branch_hazard_ctrl
// Purpose : load-use bubble and resolution-driven branch hold for the MIPS pipe
// Rev     : 1.0
// ============================================================================
module branch_hazard_ctrl #(
  parameter int MAX_WAIT = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  I_id_opcode,
  input  logic [5:0]  I_id_func,
  input  logic [4:0]  I_id_rs,
  input  logic [4:0]  I_id_rt,
  input  logic        I_ex_memread,
  input  logic [4:0]  I_ex_rt,
  input  logic        I_br_resolved,
  output logic        O_pc_stall,
  output logic        O_ifid_stall,
  output logic        O_ifid_flush,
  output logic        O_idex_bubble,
  output logic        O_busy,
  output logic        O_timeout,
  output logic [15:0] O_stall_cnt
);

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_BR_WAIT = 1'b1
  } state_t;

  localparam logic [3:0] c_WAIT_LAST = 4'(MAX_WAIT - 1);

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_wait_cnt;
  logic [3:0]  w_wait_cnt_next;
  logic        r_timeout;
  logic        w_timeout_set;
  logic [15:0] r_stall_cnt;

  logic w_ct;
  logic w_lu;
  logic w_pc_stall;
  logic w_ifid_stall;
  logic w_ifid_flush;
  logic w_idex_bubble;

  always_comb begin
    w_ct = 1'b0;
    case (I_id_opcode)
      6'b000100, 6'b000101, 6'b000110, 6'b000111,
      6'b000010, 6'b000011: w_ct = 1'b1;
      6'b000000:            w_ct = (I_id_func == 6'b001000) || (I_id_func == 6'b001001);
      default:              w_ct = 1'b0;
    endcase
  end

  assign w_lu = I_ex_memread && (I_ex_rt != 5'd0) &&
                ((I_ex_rt == I_id_rs) || (I_ex_rt == I_id_rt));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_wait_cnt <= 4'd0;
    end else begin
      r_state    <= w_next;
      r_wait_cnt <= w_wait_cnt_next;
    end
  end

  always_comb begin
    w_next          = r_state;
    w_wait_cnt_next = r_wait_cnt;
    w_timeout_set   = 1'b0;
    w_pc_stall      = 1'b0;
    w_ifid_stall    = 1'b0;
    w_ifid_flush    = 1'b0;
    w_idex_bubble   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // Load-use wins: the branch stays in ID and is seen again next cycle.
        if (w_lu) begin
          w_pc_stall    = 1'b1;
          w_ifid_stall  = 1'b1;
          w_idex_bubble = 1'b1;
        end else if (w_ct) begin
          w_pc_stall      = 1'b1;
          w_ifid_flush    = 1'b1;
          w_next          = ST_BR_WAIT;
          w_wait_cnt_next = 4'd0;
        end
      end
      ST_BR_WAIT: begin
        w_ifid_flush = 1'b1;
        w_pc_stall   = !I_br_resolved;
        if (I_br_resolved) begin
          w_next = ST_IDLE;
        end else if (r_wait_cnt == c_WAIT_LAST) begin
          w_next        = ST_IDLE;
          w_timeout_set = 1'b1;
        end else begin
          w_wait_cnt_next = r_wait_cnt + 4'd1;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_timeout   <= 1'b0;
      r_stall_cnt <= 16'd0;
    end else begin
      if (w_timeout_set) begin
        r_timeout <= 1'b1;
      end
      if (w_pc_stall && (r_stall_cnt != 16'hFFFF)) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end
    end
  end

  // Pipeline controls are forced quiet while reset is held.
  assign O_pc_stall    = w_pc_stall    & ~rst;
  assign O_ifid_stall  = w_ifid_stall  & ~rst;
  assign O_ifid_flush  = w_ifid_flush  & ~rst;
  assign O_idex_bubble = w_idex_bubble & ~rst;
  assign O_busy        = (r_state == ST_BR_WAIT);
  assign O_timeout     = r_timeout;
  assign O_stall_cnt   = r_stall_cnt;

endmodule
`default_nettype wire

// File: doc/branch_hazard_ctrl.md
# branch_hazard_ctrl

Pipeline hazard controller for the 5-stage MIPS core. It watches the instruction in ID and the load in EX, and drives the stall, flush and bubble controls for PC, IF/ID and ID/EX. Control-transfer instructions hold fetch until EX reports resolution, with a watchdog as backstop. Load-use dependencies insert a single bubble. It replaces the fixed one-cycle nop insertion with a resolution-driven sequence.

## Interface
Parameters:
- MAX_WAIT, default 7: maximum BR_WAIT cycles before the watchdog aborts the wait (legal range 2..15).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- I_id_opcode  in  6  opcode of the instruction in ID.
- I_id_func  in  6  func field of the instruction in ID.
- I_id_rs  in  5  rs field of the instruction in ID.
- I_id_rt  in  5  rt field of the instruction in ID.
- I_ex_memread  in  1  instruction in EX is a load.
- I_ex_rt  in  5  destination register of the load in EX.
- I_br_resolved  in  1  EX has resolved the outstanding control transfer; PC target is valid this cycle.
- O_pc_stall  out  1  hold PC.
- O_ifid_stall  out  1  hold the IF/ID register.
- O_ifid_flush  out  1  load a nop into IF/ID.
- O_idex_bubble  out  1  load a nop into ID/EX.
- O_busy  out  1  FSM is not IDLE.
- O_timeout  out  1  sticky; the watchdog fired at least once since reset.
- O_stall_cnt  out  16  saturating count of cycles with O_pc_stall=1.

## Operation
- Control transfer (CT) when I_id_opcode is one of 000100 beq, 000101 bne, 000110 blez, 000111 bgtz, 000010 j, 000011 jal; or when opcode=000000 and func is one of 001000 jr, 001001 jalr.
- Load-use (LU) when I_ex_memread=1, I_ex_rt!=0, and I_ex_rt==I_id_rs or I_ex_rt==I_id_rt.
- FSM states:
  - IDLE
    - If LU: O_pc_stall=O_ifid_stall=O_idex_bubble=1 combinationally. Stay IDLE. LU takes priority over CT in the same cycle.
    - Else if CT: O_pc_stall=1 and O_ifid_flush=1 combinationally; the sequential successor in IF is discarded and the CT advances to EX. Next state is BR_WAIT and wait_cnt clears to 0.
    - Else: all controls 0.
  - BR_WAIT
    - O_busy=1 and O_ifid_flush=1.
    - O_pc_stall=1, except in a cycle with I_br_resolved=1, where it is 0 so the datapath loads the target.
    - On I_br_resolved=1: next state IDLE.
    - Else if wait_cnt==MAX_WAIT-1: next state IDLE and O_timeout set to 1.
    - Else wait_cnt increments.
    - LU and CT inputs are ignored in BR_WAIT.
- I_br_resolved in IDLE is ignored.
- wait_cnt is 4 bits.
- O_stall_cnt increments on every cycle with O_pc_stall=1 and holds at 16'hFFFF.

## Timing
- Reset values: state IDLE, wait_cnt 0, O_timeout 0, O_stall_cnt 0, O_busy 0. While rst=1, all stall, flush and bubble outputs are forced to 0.
- Asserting rst mid-BR_WAIT returns the FSM to IDLE immediately; no timeout is recorded.
- LU and CT controls are combinational from the ID/EX inputs, valid in the same cycle. O_busy is registered (Moore).
- Each LU costs exactly 1 stall cycle; the load leaves EX on the next edge.
- CT in ID at cycle T: flush/stall at T; BR_WAIT for T+1..T+k, where k is the cycle with I_br_resolved=1. PC is released at T+k.
- Watchdog with no resolve: BR_WAIT lasts exactly MAX_WAIT cycles. IDLE is reached after the MAX_WAIT-th BR_WAIT cycle, and O_timeout reads 1 from then on.
- A CT present in ID on the cycle the FSM returns to IDLE is detected normally, so back-to-back branches are supported.

## Test plan
- Reset, then ID=add (opcode 000000, func 100000), I_ex_memread=0 -> all controls 0, O_busy=0, O_stall_cnt=0.
- lw $5 in EX (I_ex_memread=1, I_ex_rt=5); ID uses rs=5 -> one cycle with pc_stall=ifid_stall=idex_bubble=1. With I_ex_rt=0 -> no stall. O_stall_cnt=1 after the first case.
- beq in ID at cycle 0; I_br_resolved pulsed at cycle 2 -> cycle 0: pc_stall=1, ifid_flush=1. Cycles 1–2: O_busy=1. pc_stall=1 at cycle 1 and 0 at cycle 2. IDLE at cycle 3. O_stall_cnt=2.
- jr (000000/001000) in ID, never resolved, MAX_WAIT=7 -> BR_WAIT for 7 cycles, then IDLE with O_timeout=1. O_timeout stays 1 through a later normal branch.
- LU and beq simultaneously (load rt=3, beq rs=3) -> LU bubble only, FSM stays IDLE. The next cycle the CT is detected and BR_WAIT entered.
- rst asserted during BR_WAIT cycle 2 -> outputs 0 immediately, O_busy=0, O_timeout=0, O_stall_cnt=0. Also force 65540 stall cycles -> O_stall_cnt=16'hFFFF.
